// File: rtl/tlul_pkg.sv
// Minimal TileLink-UL (TL-UL) channel definitions for a 32-bit register port.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/vicuna_cluster_ctrl_pkg.sv
// Shared types and register map of the Vicuna cluster controller.
package vicuna_cluster_ctrl_pkg;

    // Per-core sequencer state; the encoding is what STATUS reports.
    typedef enum logic [1:0] {
        CORE_IDLE  = 2'd0,
        CORE_RESET = 2'd1,
        CORE_RUN   = 2'd2,
        CORE_DONE  = 2'd3
    } core_state_e;

    // Byte offsets within the register window.
    localparam logic [7:0] REG_CTRL           = 8'h00;
    localparam logic [7:0] REG_STATUS         = 8'h04;
    localparam logic [7:0] REG_INTR_STATE     = 8'h08;
    localparam logic [7:0] REG_INTR_ENABLE    = 8'h0C;
    localparam logic [7:0] REG_BOOT_ADDR_BASE = 8'h10;
    localparam logic [7:0] REG_CYCLES_BASE    = 8'h30;

    // CTRL bit i starts core i, bit CTRL_HALT_OFFSET+i halts it.
    localparam int unsigned CTRL_HALT_OFFSET = 8;
    localparam int unsigned MAX_CORES        = 8;

endpackage

// File: rtl/vicuna_core_seq.sv
// Sequencer for one Vicuna core: reset hold, run enable and run-cycle counter.
module vicuna_core_seq
    import vicuna_cluster_ctrl_pkg::*;
#(
    parameter int unsigned ResetCycles = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic        done_i,
    output core_state_e state_o,
    output logic        core_rst_no,
    output logic        fetch_en_o,
    output logic [31:0] cycles_o,
    output logic        done_evt_o
);

    localparam int unsigned CntW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(ResetCycles - 1);

    core_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     cycles_q, cycles_d;
    logic            rst_n_q, fetch_q;

    // Next-state logic; halt always takes priority over start and done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cycles_d   = cycles_q;
        done_evt_o = 1'b0;
        case (state_q)
            CORE_IDLE, CORE_DONE: begin
                if (start_i && !halt_i) begin
                    state_d  = CORE_RESET;
                    cnt_d    = CntLoad;
                    cycles_d = '0;
                end
            end
            CORE_RESET: begin
                if (halt_i) begin
                    state_d = CORE_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = CORE_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CORE_RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (halt_i) begin
                    state_d = CORE_IDLE;
                end else if (done_i) begin
                    state_d    = CORE_DONE;
                    done_evt_o = 1'b1;
                end
            end
            default: state_d = CORE_IDLE;
        endcase
    end

    // State, counters and registered core controls (glitch-free reset line).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= CORE_IDLE;
            cnt_q    <= '0;
            cycles_q <= '0;
            rst_n_q  <= 1'b0;
            fetch_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            rst_n_q  <= (state_d == CORE_RUN);
            fetch_q  <= (state_d == CORE_RUN);
        end
    end

    assign state_o     = state_q;
    assign core_rst_no = rst_n_q;
    assign fetch_en_o  = fetch_q;
    assign cycles_o    = cycles_q;

endmodule

// File: rtl/vicuna_cluster_ctrl.sv
// TL-UL register block that sequences the Vicuna worker cores of one cluster.
// Handshake: a request is accepted when a_valid && a_ready, with a_ready = !d_valid;
// the response is presented the next cycle and held until d_valid && d_ready.
module vicuna_cluster_ctrl
    import vicuna_cluster_ctrl_pkg::*;
#(
    parameter int unsigned NumCores        = 2,
    parameter int unsigned ResetCycles     = 4,
    parameter logic [31:0] BootAddrDefault = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  tlul_pkg::tl_h2d_t            tl_i,
    output tlul_pkg::tl_d2h_t            tl_o,
    output logic [NumCores-1:0]          core_rst_no,
    output logic [NumCores-1:0]          core_fetch_en_o,
    output logic [NumCores-1:0][31:0]    core_boot_addr_o,
    input  logic [NumCores-1:0]          core_done_i,
    output logic                         intr_done_o
);

    core_state_e                core_state [NumCores];
    logic [31:0]                cycles     [NumCores];
    logic [NumCores-1:0]        done_evt, busy, boot_sel, start_vec, halt_vec, intr_clr;
    logic [NumCores-1:0]        intr_state_q, intr_state_d, intr_en_q;
    logic [NumCores-1:0][31:0]  boot_q;
    logic                       intr_q;

    logic        d_valid_q, d_error_q;
    logic [2:0]  d_opcode_q;
    logic [1:0]  d_size_q;
    logic [7:0]  d_source_q;
    logic [31:0] d_data_q;

    logic        a_ready, a_hs, is_get, is_put, hit, err, we;
    logic [7:0]  addr;
    logic [31:0] rdata, status_w;

    // Only the low byte is decoded; the crossbar selects this device.
    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:8]};

    assign a_ready = !d_valid_q;
    assign a_hs    = tl_i.a_valid && a_ready;
    assign addr    = tl_i.a_address[7:0];
    assign is_get  = (tl_i.a_opcode == tlul_pkg::Get);
    assign is_put  = (tl_i.a_opcode == tlul_pkg::PutFullData) ||
                     (tl_i.a_opcode == tlul_pkg::PutPartialData);

    // Address decode, read mux and error classification.
    always_comb begin
        hit      = 1'b0;
        rdata    = '0;
        boot_sel = '0;
        busy     = '0;
        status_w = '0;
        for (int i = 0; i < NumCores; i++) begin
            status_w[2*i +: 2] = core_state[i];
            busy[i] = (core_state[i] == CORE_RESET) || (core_state[i] == CORE_RUN);
            if (addr == REG_BOOT_ADDR_BASE + 8'(4*i)) begin
                hit         = 1'b1;
                boot_sel[i] = 1'b1;
                rdata       = boot_q[i];
            end
            if (addr == REG_CYCLES_BASE + 8'(4*i)) begin
                hit   = 1'b1;
                rdata = cycles[i];
            end
        end
        case (addr)
            REG_CTRL:        hit = 1'b1;
            REG_STATUS:      begin hit = 1'b1; rdata = status_w; end
            REG_INTR_STATE:  begin hit = 1'b1; rdata[NumCores-1:0] = intr_state_q; end
            REG_INTR_ENABLE: begin hit = 1'b1; rdata[NumCores-1:0] = intr_en_q; end
            default: ;
        endcase
        err = !hit || (tl_i.a_size != 2'd2) || (tl_i.a_mask != 4'hF) ||
              !(is_get || is_put) || (is_put && |(boot_sel & busy));
    end

    assign we        = a_hs && is_put && !err;
    assign start_vec = (we && addr == REG_CTRL) ? tl_i.a_data[NumCores-1:0] : '0;
    assign halt_vec  = (we && addr == REG_CTRL) ? tl_i.a_data[CTRL_HALT_OFFSET +: NumCores] : '0;
    assign intr_clr  = (we && addr == REG_INTR_STATE) ? tl_i.a_data[NumCores-1:0] : '0;
    // A new completion event wins over a simultaneous software clear.
    assign intr_state_d = (intr_state_q & ~intr_clr) | done_evt;

    for (genvar g = 0; g < NumCores; g++) begin : g_core
        vicuna_core_seq #(
            .ResetCycles (ResetCycles)
        ) u_seq (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .start_i     (start_vec[g]),
            .halt_i      (halt_vec[g]),
            .done_i      (core_done_i[g]),
            .state_o     (core_state[g]),
            .core_rst_no (core_rst_no[g]),
            .fetch_en_o  (core_fetch_en_o[g]),
            .cycles_o    (cycles[g]),
            .done_evt_o  (done_evt[g])
        );
    end

    // Response channel: capture on accept, hold until the host takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_valid_q  <= 1'b0;
            d_error_q  <= 1'b0;
            d_opcode_q <= tlul_pkg::AccessAck;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
        end else if (a_hs) begin
            d_valid_q  <= 1'b1;
            d_error_q  <= err;
            d_opcode_q <= is_get ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
            d_size_q   <= tl_i.a_size;
            d_source_q <= tl_i.a_source;
            d_data_q   <= (is_get && !err) ? rdata : '0;
        end else if (d_valid_q && tl_i.d_ready) begin
            d_valid_q  <= 1'b0;
        end
    end

    // Software-visible registers and the registered interrupt line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intr_state_q <= '0;
            intr_en_q    <= '0;
            boot_q       <= {NumCores{BootAddrDefault}};
            intr_q       <= 1'b0;
        end else begin
            intr_state_q <= intr_state_d;
            intr_q       <= |(intr_state_q & intr_en_q);
            if (we && addr == REG_INTR_ENABLE) begin
                intr_en_q <= tl_i.a_data[NumCores-1:0];
            end
            for (int i = 0; i < NumCores; i++) begin
                if (we && boot_sel[i]) begin
                    boot_q[i] <= tl_i.a_data;
                end
            end
        end
    end

    // Drive the response struct from the response registers.
    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_size   = d_size_q;
        tl_o.d_source = d_source_q;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
        tl_o.a_ready  = a_ready;
    end

    assign core_boot_addr_o = boot_q;
    assign intr_done_o      = intr_q;

endmodule
